// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Responder side of the CPU data-memory port. It accepts one load or store
//   over a valid/ready request channel and returns exactly one response over a
//   valid/ready response channel. Storage is a word-organised RAM with byte-lane
//   write enables. LATENCY wait states sit between acceptance and response.
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   rst_ni       asynchronous reset, active low; also clears the RAM
//   req_valid_i  request present
//   req_ready_o  responder can accept a request (high only in IDLE)
//   req_we_i     1 = store, 0 = load
//   req_addr_i   byte address
//   req_wdata_i  store data; lane i is bits [8i+7:8i]
//   req_be_i     store byte-lane enables; ignored for loads
//   rsp_valid_o  response present (high only in RESP)
//   rsp_ready_i  requester accepts the response
//   rsp_rdata_o  load data; 0 for stores and errors
//   rsp_err_o    request was misaligned or out of range
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ENTRY_COUNT = 32,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int          IDX_W    = $clog2(ENTRY_COUNT);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [29:0] WORDS    = 30'(ENTRY_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // Captured request
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] mem_q [ENTRY_COUNT];

    // Commit-side view of the request. With zero wait states the commit happens
    // on the accept edge itself, so the live request inputs are used directly
    // instead of the (not yet loaded) capture registers.
    logic             accept;
    logic             commit;
    logic             c_we;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [3:0]       c_be;
    logic             c_err;
    logic [IDX_W-1:0] c_idx;
    logic [31:0]      old_word;
    logic [31:0]      wr_word_d;
    logic [31:0]      rdata_d;
    logic             mem_we;

    always_comb begin
        accept  = (state_q == IDLE) && req_valid_i && ready_q;
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        commit  = (state_q == WAIT) && (cnt_q == 4'd0);
        if (LATENCY == 0) begin
            c_we    = req_we_i;
            c_addr  = req_addr_i;
            c_wdata = req_wdata_i;
            c_be    = req_be_i;
            commit  = accept;
        end

        // Out-of-range words error out rather than aliasing onto low words.
        c_err    = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= WORDS);
        c_idx    = c_addr[IDX_W+1:2];
        old_word = mem_q[c_idx];

        for (int i = 0; i < 4; i++) begin
            wr_word_d[8*i +: 8] = c_be[i] ? c_wdata[8*i +: 8] : old_word[8*i +: 8];
        end

        rdata_d = (c_err || c_we) ? 32'd0 : old_word;
        mem_we  = commit && c_we && !c_err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        be_q    <= req_be_i;
                        ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        rdata_q <= 32'd0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase

            // Edge entering RESP: perform the write / sample the read word.
            if (commit) begin
                valid_q <= 1'b1;
                rdata_q <= rdata_d;
                err_q   <= c_err;
                if (mem_we) begin
                    mem_q[c_idx] <= wr_word_d;
                end
            end
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule
